// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: access sizes, lane-select
// constants, FSM encoding and the misalignment rule.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    localparam logic [3:0] SEL_NONE = 4'h0;
    localparam logic [3:0] SEL_ALL  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_HALF2 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    // The reserved size is reported as misaligned so it never reaches the RAM.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_RSVD) ||
               (size == SZ_HALF && lo[0]) ||
               (size == SZ_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data extraction: picks the addressed byte or half-word out of a RAM
// word and sign- or zero-extends it; word loads pass straight through.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        case (i_size)
            SZ_BYTE: o_rdata = {{24{~i_uns & w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = {{16{~i_uns & w_half[15]}}, w_half};
            default: o_rdata = i_word;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port (CPU / DMA-debug) front end for the byte-lane data RAM: arbitrates,
// turns byte/half/word accesses into legal lane selects and aligns load data.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [1:0]        a_size,
    input  logic              a_uns,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [31:0]       a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [1:0]        b_size,
    input  logic              b_uns,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [31:0]       b_rdata,
    output logic [ADDR_W-3:0] ram_addres,
    output logic [3:0]        ram_sel,
    output logic              ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    state_t              r_state;
    port_t               r_ptr;
    port_t               r_gnt;
    port_t               w_pick;
    logic                r_we;
    logic                r_uns;
    logic                r_mis;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_word;

    logic [1:0]          w_lane;
    logic [3:0]          w_sel;
    logic                w_we;
    logic                w_full;
    logic [7:0]          w_st_byte;
    logic [31:0]         w_ld;
    logic                w_resp;

    always_comb begin
        w_pick = PORT_A;
        if (a_req && b_req) begin
            w_pick = (FIXED_PRI || r_ptr == PORT_A) ? PORT_A : PORT_B;
        end else if (b_req) begin
            w_pick = PORT_B;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_ptr   <= PORT_A;
            r_gnt   <= PORT_A;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_mis   <= 1'b0;
            r_size  <= SZ_BYTE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_word  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (a_req || b_req) begin
                        r_gnt   <= w_pick;
                        r_state <= ST_ACC;
                        if (w_pick == PORT_A) begin
                            r_we    <= a_we;
                            r_uns   <= a_uns;
                            r_size  <= a_size;
                            r_addr  <= a_addr;
                            r_wdata <= a_wdata;
                            r_mis   <= is_misaligned(a_size, a_addr[1:0]);
                        end else begin
                            r_we    <= b_we;
                            r_uns   <= b_uns;
                            r_size  <= b_size;
                            r_addr  <= b_addr;
                            r_wdata <= b_wdata;
                            r_mis   <= is_misaligned(b_size, b_addr[1:0]);
                        end
                    end
                end
                ST_ACC: begin
                    r_word  <= ram_dout;
                    r_state <= (!r_mis && r_we && r_size == SZ_HALF) ? ST_HALF2 : ST_RESP;
                end
                ST_HALF2: r_state <= ST_RESP;
                default: begin
                    if (!FIXED_PRI) begin
                        r_ptr <= (r_gnt == PORT_A) ? PORT_B : PORT_A;
                    end
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_lane = r_addr[1:0];

    // A half store is split into two single-lane writes because the RAM decoder
    // only honours one-hot or all-lane selects.
    always_comb begin
        w_sel     = SEL_NONE;
        w_we      = 1'b0;
        w_full    = 1'b0;
        w_st_byte = r_wdata[7:0];
        if (r_state == ST_ACC && !r_mis) begin
            w_we = r_we;
            if (!r_we || r_size == SZ_WORD) begin
                w_sel  = SEL_ALL;
                w_full = 1'b1;
            end else begin
                w_sel = 4'b0001 << w_lane;
            end
        end else if (r_state == ST_HALF2) begin
            w_we      = 1'b1;
            w_sel     = 4'b0001 << (w_lane + 2'd1);
            w_st_byte = r_wdata[15:8];
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign ram_din[8*gi +: 8] = !(w_we && w_sel[gi]) ? 8'h00 :
                                        w_full ? r_wdata[8*gi +: 8] : w_st_byte;
        end
    endgenerate

    assign ram_sel    = w_sel;
    assign ram_we     = w_we && !RST;
    assign ram_addres = (r_state == ST_ACC || r_state == ST_HALF2) ? r_addr[ADDR_W-1:2] : '0;

    dmem_load_align u_load_align (
        .i_word    (r_word),
        .i_addr_lo (r_addr[1:0]),
        .i_size    (r_size),
        .i_uns     (r_uns),
        .o_rdata   (w_ld)
    );

    assign w_resp  = (r_state == ST_RESP);
    assign a_ack   = w_resp && (r_gnt == PORT_A);
    assign b_ack   = w_resp && (r_gnt == PORT_B);
    assign a_err   = a_ack && r_mis;
    assign b_err   = b_ack && r_mis;
    assign a_rdata = (a_ack && !r_mis && !r_we) ? w_ld : 32'd0;
    assign b_rdata = (b_ack && !r_mis && !r_we) ? w_ld : 32'd0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a directed vector table, arbitration and
// reset-in-flight sequences, then random traffic against a byte-memory model.
module tb_dmem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        a_req, a_we, a_uns, b_req, b_we, b_uns;
    logic [1:0]  a_size, b_size;
    logic [11:0] a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_ack, a_err, b_ack, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [9:0]  ram_addres;
    logic [3:0]  ram_sel;
    logic        ram_we;
    logic [31:0] ram_din, ram_dout;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dmem_port_arbiter #(.ADDR_W(12), .FIXED_PRI(1'b0)) dut (
        .CLK(CLK), .RST(RST),
        .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_uns(a_uns), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_uns(b_uns), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .ram_addres(ram_addres), .ram_sel(ram_sel), .ram_we(ram_we),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Byte-lane RAM: asynchronous read, lane-masked write on the clock edge.
    logic [31:0] ram_mem [0:1023];
    logic [7:0]  shadow  [0:4095];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] sel);
        logic [31:0] w = old;
        for (int l = 0; l < 4; l++) if (sel[l]) w[8*l +: 8] = din[8*l +: 8];
        return w;
    endfunction

    assign ram_dout = ram_mem[ram_addres];
    always @(posedge CLK) if (ram_we) ram_mem[ram_addres] <= merge(ram_mem[ram_addres], ram_din, ram_sel);

    // Reference model: a flat little-endian byte memory.
    function automatic bit ref_mis(input logic [1:0] size, input logic [11:0] addr);
        return size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input bit uns, input logic [11:0] addr);
        int a = int'(addr);
        logic [31:0] v;
        case (size)
            2'd0: v = uns ? {24'h0, shadow[a]} : {{24{shadow[a][7]}}, shadow[a]};
            2'd1: v = uns ? {16'h0, shadow[a+1], shadow[a]} : {{16{shadow[a+1][7]}}, shadow[a+1], shadow[a]};
            default: v = {shadow[a+3], shadow[a+2], shadow[a+1], shadow[a]};
        endcase
        return v;
    endfunction

    function automatic logic [31:0] shadow_word(input logic [11:0] addr);
        int b = int'({addr[11:2], 2'b00});
        return {shadow[b+3], shadow[b+2], shadow[b+1], shadow[b]};
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [11:0] addr, input logic [31:0] wdata);
        for (int i = 0; i < (1 << size); i++) shadow[int'(addr) + i] = wdata[8*i +: 8];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit port, input bit req, input bit we, input logic [1:0] size,
                         input bit uns, input logic [11:0] addr, input logic [31:0] wdata);
        if (!port) begin
            a_req = req; a_we = we; a_size = size; a_uns = uns; a_addr = addr; a_wdata = wdata;
        end else begin
            b_req = req; b_we = we; b_size = size; b_uns = uns; b_addr = addr; b_wdata = wdata;
        end
    endtask

    task automatic run_txn(input string tag, input bit port, input bit we, input logic [1:0] size,
                           input bit uns, input logic [11:0] addr, input logic [31:0] wdata,
                           input bit exp_err, input logic [31:0] exp_rd, input int exp_lat,
                           input int exp_nwr, input logic [3:0] exp_sel0);
        bit got = 0, bad_sel = 0, oth_bad = 0, g_err = 0;
        int lat = -1, nwr = 0;
        logic [3:0]  sel0 = 4'h0;
        logic [31:0] g_rd = 32'h0;
        @(posedge CLK); #1;
        drive(port, 1'b1, we, size, uns, addr, wdata);
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (ram_we) begin
                if (nwr == 0) sel0 = ram_sel;
                nwr++;
            end
            if (!(ram_sel inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'hF})) bad_sel = 1;
            if (port ? (a_ack || a_rdata != 0) : (b_ack || b_rdata != 0)) oth_bad = 1;
            if (port ? b_ack : a_ack) begin
                got = 1; lat = c;
                g_err = port ? b_err : a_err;
                g_rd  = port ? b_rdata : a_rdata;
                break;
            end
        end
        chk({tag, " ack_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
            chk({tag, " err"}, 32'(g_err), 32'(exp_err));
            chk({tag, " rdata"}, g_rd, exp_rd);
            chk({tag, " ram_writes"}, 32'(nwr), 32'(exp_nwr));
            if (exp_nwr > 0) chk({tag, " first_sel"}, 32'(sel0), 32'(exp_sel0));
            chk({tag, " legal_sel"}, 32'(bad_sel), 32'd0);
            chk({tag, " other_port_quiet"}, 32'(oth_bad), 32'd0);
        end
        @(posedge CLK); #1;
        drive(port, 1'b0, we, size, uns, addr, wdata);
        @(negedge CLK);
        chk({tag, " ack_one_cycle"}, 32'(port ? b_ack : a_ack), 32'd0);
        if (we && !ref_mis(size, addr)) ref_store(size, addr, wdata);
        chk({tag, " mem_word"}, ram_mem[addr[11:2]], shadow_word(addr));
        $display("txn %s port=%s we=%0d size=%0d uns=%0d addr=0x%03h wdata=0x%08h err=%0d rdata=0x%08h lat=%0d",
                 tag, port ? "B" : "A", we, size, uns, addr, wdata, g_err, g_rd, lat);
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [11:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rd;
        int          lat;
        int          nwr;
        logic [3:0]  sel0;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  expect_b, last_cyc, cyc;
        bit  found;
        bit  r_port, r_we, r_uns, mis;
        logic [1:0]  r_size;
        logic [11:0] r_addr;
        logic [31:0] r_wdata, exp_rd;

        for (int i = 0; i < 1024; i++) ram_mem[i] = 32'h0;
        for (int i = 0; i < 4096; i++) shadow[i] = 8'h0;

        // The 0x1000 store address of the original scenario wraps to 0x000 at 12 bits.
        vecs[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 12'h000, 32'h7FFFFFFF, 1'b0, 32'h00000000, 2, 1, 4'hF};
        vecs[1]  = '{1'b0, 1'b0, 2'd2, 1'b0, 12'h000, 32'h00000000, 1'b0, 32'h7FFFFFFF, 2, 0, 4'h0};
        vecs[2]  = '{1'b0, 1'b1, 2'd0, 1'b0, 12'h003, 32'h123456A5, 1'b0, 32'h00000000, 2, 1, 4'h8};
        vecs[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 12'h003, 32'h00000000, 1'b0, 32'hFFFFFFA5, 2, 0, 4'h0};
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 1'b1, 12'h003, 32'h00000000, 1'b0, 32'h000000A5, 2, 0, 4'h0};
        vecs[5]  = '{1'b0, 1'b1, 2'd1, 1'b0, 12'h006, 32'hCAFEBEEF, 1'b0, 32'h00000000, 3, 2, 4'h4};
        vecs[6]  = '{1'b0, 1'b0, 2'd2, 1'b0, 12'h004, 32'h00000000, 1'b0, 32'hBEEF0000, 2, 0, 4'h0};
        vecs[7]  = '{1'b0, 1'b1, 2'd2, 1'b0, 12'h002, 32'h11111111, 1'b1, 32'h00000000, 2, 0, 4'h0};
        vecs[8]  = '{1'b0, 1'b0, 2'd1, 1'b0, 12'h001, 32'h00000000, 1'b1, 32'h00000000, 2, 0, 4'h0};
        vecs[9]  = '{1'b1, 1'b0, 2'd1, 1'b0, 12'h006, 32'h00000000, 1'b0, 32'hFFFFBEEF, 2, 0, 4'h0};
        vecs[10] = '{1'b1, 1'b0, 2'd1, 1'b1, 12'h006, 32'h00000000, 1'b0, 32'h0000BEEF, 2, 0, 4'h0};
        vecs[11] = '{1'b1, 1'b1, 2'd3, 1'b0, 12'h008, 32'h22222222, 1'b1, 32'h00000000, 2, 0, 4'h0};
        vecs[12] = '{1'b1, 1'b0, 2'd0, 1'b0, 12'h000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 2, 0, 4'h0};
        vecs[13] = '{1'b1, 1'b0, 2'd0, 1'b1, 12'h001, 32'h00000000, 1'b0, 32'h000000FF, 2, 0, 4'h0};
        vecs[14] = '{1'b1, 1'b1, 2'd1, 1'b0, 12'h002, 32'h00001234, 1'b0, 32'h00000000, 3, 2, 4'h4};
        vecs[15] = '{1'b0, 1'b0, 2'd2, 1'b0, 12'h000, 32'h00000000, 1'b0, 32'h1234FFFF, 2, 0, 4'h0};

        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 12'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 12'h0, 32'h0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset flags", 32'({a_ack, a_err, b_ack, b_err, ram_we}), 32'd0);
        chk("reset a_rdata", a_rdata, 32'h0);
        chk("reset b_rdata", b_rdata, 32'h0);
        chk("reset ram_sel", 32'(ram_sel), 32'h0);
        chk("reset ram_din", ram_din, 32'h0);
        chk("reset ram_addres", 32'(ram_addres), 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].size, vecs[i].uns,
                    vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].rd, vecs[i].lat,
                    vecs[i].nwr, vecs[i].sel0);
        end

        // Reset lands while a half store is in its second write cycle.
        @(posedge CLK); #1;
        drive(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 12'h00A, 32'h00007788);
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_half acc ram_we", 32'(ram_we), 32'd1);
        chk("rst_half acc ram_sel", 32'(ram_sel), 32'h4);
        chk("rst_half acc ram_din", ram_din, 32'h00880000);
        @(posedge CLK); #1;
        RST = 1'b1;
        a_req = 1'b0;
        @(negedge CLK);
        chk("rst_half half2 ram_we gated", 32'(ram_we), 32'd0);
        chk("rst_half half2 no ack", 32'(a_ack), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_half idle flags", 32'({a_ack, a_err, b_ack, b_err, ram_we}), 32'd0);
        chk("rst_half idle ram_sel", 32'(ram_sel), 32'h0);
        chk("rst_half idle ram_din", ram_din, 32'h0);
        shadow[12'h00A] = 8'h88;
        chk("rst_half mem_word", ram_mem[2], shadow_word(12'h008));
        run_txn("rst_half reload", 1'b0, 1'b0, 2'd2, 1'b0, 12'h008, 32'h0, 1'b0,
                ref_load(2'd2, 1'b0, 12'h008), 2, 0, 4'h0);

        // Both ports hold requests continuously: grants must alternate from A.
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 12'h000, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 12'h004, 32'h0);
        expect_b = 0;
        last_cyc = -1;
        cyc = 0;
        for (int g = 0; g < 4; g++) begin
            found = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge CLK);
                cyc++;
                if (a_ack || b_ack) begin
                    found = 1;
                    break;
                end
            end
            chk($sformatf("arb%0d ack_seen", g), 32'(found), 32'd1);
            if (found) begin
                chk($sformatf("arb%0d single_ack", g), 32'(a_ack && b_ack), 32'd0);
                chk($sformatf("arb%0d granted_b", g), 32'(b_ack), 32'(expect_b));
                if (b_ack) chk($sformatf("arb%0d rdata", g), b_rdata, ref_load(2'd2, 1'b0, 12'h004));
                else       chk($sformatf("arb%0d rdata", g), a_rdata, ref_load(2'd2, 1'b0, 12'h000));
                if (last_cyc >= 0) chk($sformatf("arb%0d spacing", g), 32'(cyc - last_cyc), 32'd3);
                $display("txn arb%0d granted=%s cycle=%0d", g, b_ack ? "B" : "A", cyc);
                last_cyc = cyc;
            end
            expect_b = 1 - expect_b;
        end
        @(posedge CLK); #1;
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge CLK);
        chk("arb idle acks", 32'({a_ack, b_ack}), 32'd0);

        for (int n = 0; n < 200; n++) begin
            r_port  = 1'($urandom_range(0, 1));
            r_we    = 1'($urandom_range(0, 1));
            r_uns   = 1'($urandom_range(0, 1));
            r_size  = 2'($urandom_range(0, 3));
            r_addr  = 12'($urandom_range(0, 63));
            r_wdata = $urandom;
            mis     = ref_mis(r_size, r_addr);
            exp_rd  = (!r_we && !mis) ? ref_load(r_size, r_uns, r_addr) : 32'h0;
            run_txn($sformatf("rnd%0d", n), r_port, r_we, r_size, r_uns, r_addr, r_wdata, mis, exp_rd,
                    (r_we && !mis && r_size == 2'd1) ? 3 : 2,
                    (r_we && !mis) ? ((r_size == 2'd1) ? 2 : 1) : 0,
                    (r_size == 2'd2) ? 4'hF : (4'b0001 << r_addr[1:0]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
